// File: rtl/deserializer.sv
// Serial-to-parallel word assembler, LSB first, framed by frame_start.
// One-word output register with valid/ready drain and overflow/frame error pulses.
module deserializer #(
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  resetn,
   input  logic                  din,
   input  logic                  din_en,
   input  logic                  frame_start,
   output logic [DATA_WIDTH-1:0] dout,
   output logic                  dout_valid,
   input  logic                  dout_ready,
   output logic                  overflow,
   output logic                  frame_err
);

   localparam int CW = $clog2(DATA_WIDTH);
   localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);

   typedef enum logic {
      IDLE,
      SHIFT
   } state_t;

   state_t                  state;
   logic [CW-1:0]           count;
   logic [DATA_WIDTH-1:0]   shreg;
   logic [DATA_WIDTH-1:0]   word;
   logic                    can_load;

   // Partial word with the current bit merged in at its position.
   always_comb begin
      word        = shreg;
      word[count] = din;
   end

   assign can_load = !dout_valid || dout_ready;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state      <= IDLE;
         count      <= '0;
         shreg      <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         overflow   <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         overflow  <= 1'b0;
         frame_err <= 1'b0;
         if (dout_valid && dout_ready)
            dout_valid <= 1'b0;
         if (din_en) begin
            if (frame_start) begin
               // A new frame always wins, even over a completing bit.
               frame_err <= (state == SHIFT);
               shreg     <= {{(DATA_WIDTH-1){1'b0}}, din};
               count     <= CW'(1);
               state     <= SHIFT;
            end else if (state == SHIFT) begin
               if (count == LAST) begin
                  state <= IDLE;
                  count <= '0;
                  shreg <= '0;
                  if (can_load) begin
                     dout       <= word;
                     dout_valid <= 1'b1;
                  end else begin
                     overflow <= 1'b1;
                  end
               end else begin
                  shreg <= word;
                  count <= count + CW'(1);
               end
            end
         end
      end
   end

endmodule
